// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard sources in, stall/flush controls out.
// The master drives the hazard sources; the slave (controller) drives the controls.
interface pipe_hazard_ctrl_if #(
  parameter int ASIZE = 5,
  parameter int SCW   = 16
);
  logic [ASIZE-1:0] id_rs1;
  logic [ASIZE-1:0] id_rs2;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic             ex_wen;
  logic [ASIZE-1:0] ex_waddr;
  logic             br_taken;
  logic             dm_req;
  logic             dm_ready;
  logic             stall_if;
  logic             flush_if;
  logic             stall_id;
  logic             bubble_exe;
  logic             stall_exe;
  logic             bubble_wb;
  logic             dm_abort;
  logic             dm_timeout;
  logic             mem_wait;
  logic [SCW-1:0]   stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2,
    output ex_mem_read, ex_wen, ex_waddr,
    output br_taken, dm_req, dm_ready,
    input  stall_if, flush_if, stall_id,
    input  bubble_exe, stall_exe, bubble_wb,
    input  dm_abort, dm_timeout, mem_wait,
    input  stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2,
    input  ex_mem_read, ex_wen, ex_waddr,
    input  br_taken, dm_req, dm_ready,
    output stall_if, flush_if, stall_id,
    output bubble_exe, stall_exe, bubble_wb,
    output dm_abort, dm_timeout, mem_wait,
    output stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush,
// and multi-cycle data-memory wait with timeout abort plus stall statistics.
module pipe_hazard_ctrl #(
  parameter int ASIZE       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CW          = 4,
  parameter int SCW         = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  state_t          state, state_n;
  logic [CW-1:0]   wait_cnt, wait_n;
  logic            set_to;
  logic            load_use;
  logic            timeout_q;
  logic [SCW-1:0]  scnt_q;

  assign load_use = bus.ex_mem_read & bus.ex_wen &
                    (bus.ex_waddr != '0) &
                    ((bus.ex_waddr == bus.id_rs1) |
                     (bus.id_uses_rs2 &
                      (bus.ex_waddr == bus.id_rs2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      scnt_q    <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      if (set_to)
        timeout_q <= 1'b1;
      if (bus.stall_if && scnt_q != '1)
        scnt_q <= scnt_q + 1'b1;
    end
  end

  always_comb begin
    state_n        = state;
    wait_n         = wait_cnt;
    set_to         = 1'b0;
    bus.stall_if   = 1'b0;
    bus.flush_if   = 1'b0;
    bus.stall_id   = 1'b0;
    bus.bubble_exe = 1'b0;
    bus.stall_exe  = 1'b0;
    bus.bubble_wb  = 1'b0;
    bus.dm_abort   = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (bus.dm_req && !bus.dm_ready) begin
            bus.stall_if  = 1'b1;
            bus.stall_id  = 1'b1;
            bus.stall_exe = 1'b1;
            bus.bubble_wb = 1'b1;
            state_n       = MEM_WAIT;
            wait_n        = CW'(1);
          end else if (bus.br_taken) begin
            bus.flush_if   = 1'b1;
            bus.bubble_exe = 1'b1;
          end else if (load_use) begin
            bus.stall_if   = 1'b1;
            bus.bubble_exe = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (bus.dm_ready) begin
            state_n = RUN;
            wait_n  = '0;
            if (bus.br_taken) begin
              bus.flush_if   = 1'b1;
              bus.bubble_exe = 1'b1;
            end else if (load_use) begin
              bus.stall_if   = 1'b1;
              bus.bubble_exe = 1'b1;
            end
          end else if (wait_cnt < TMO) begin
            bus.stall_if  = 1'b1;
            bus.stall_id  = 1'b1;
            bus.stall_exe = 1'b1;
            bus.bubble_wb = 1'b1;
            wait_n        = wait_cnt + 1'b1;
          end else begin
            // abandon the access: squash its writeback, let the pipe move
            bus.dm_abort  = 1'b1;
            bus.bubble_wb = 1'b1;
            set_to        = 1'b1;
            state_n       = RUN;
            wait_n        = '0;
          end
        end
        default: begin
          state_n = RUN;
          wait_n  = '0;
        end
      endcase
    end
  end

  assign bus.dm_timeout = timeout_q;
  assign bus.mem_wait   = (state == MEM_WAIT);
  assign bus.stall_cnt  = scnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// control outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.ASIZE(5), .SCW(16)) bus ();

  pipe_hazard_ctrl #(
    .ASIZE(5),
    .MEM_TIMEOUT(15),
    .CW(4),
    .SCW(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {stall_if, flush_if, stall_id, bubble_exe, stall_exe, bubble_wb,
  //  dm_abort, dm_timeout, mem_wait}
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] SIF  = 9'b100000000;
  localparam logic [8:0] FIF  = 9'b010000000;
  localparam logic [8:0] SID  = 9'b001000000;
  localparam logic [8:0] BEX  = 9'b000100000;
  localparam logic [8:0] SEX  = 9'b000010000;
  localparam logic [8:0] BWB  = 9'b000001000;
  localparam logic [8:0] ABT  = 9'b000000100;
  localparam logic [8:0] TMO  = 9'b000000010;
  localparam logic [8:0] MW   = 9'b000000001;
  localparam logic [8:0] FULL = SIF | SID | SEX | BWB;

  typedef struct {
    logic [8:0]  flags;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cyc(
    input logic       r,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       u2,
    input logic       mr,
    input logic       we,
    input logic [4:0] wa,
    input logic       br,
    input logic       rq,
    input logic       rd,
    input logic [8:0] ev,
    input int         cnt,
    input string      nm
  );
    exp_t e;
    rst             = r;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_uses_rs2 = u2;
    bus.ex_mem_read = mr;
    bus.ex_wen      = we;
    bus.ex_waddr    = wa;
    bus.br_taken    = br;
    bus.dm_req      = rq;
    bus.dm_ready    = rd;
    e.flags = ev;
    e.cnt   = 16'(cnt);
    e.name  = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [8:0] ev, input int cnt, input string nm);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev, cnt, nm);
  endtask

  task automatic mreq(input logic rq, input logic rd,
                      input logic [8:0] ev, input int cnt,
                      input string nm);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, rq, rd, ev, cnt, nm);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e = q.pop_front();
      act = {bus.stall_if, bus.flush_if, bus.stall_id, bus.bubble_exe,
             bus.stall_exe, bus.bubble_wb, bus.dm_abort, bus.dm_timeout,
             bus.mem_wait};
      n_cmp++;
      if (act !== e.flags) begin
        n_bad++;
        $display("FAIL %s flags: got %b want %b", e.name, act, e.flags);
      end
      n_cmp++;
      if (bus.stall_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s stall_cnt: got %0d want %0d",
                 e.name, bus.stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs2 = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_wen = 1'b0; bus.ex_waddr = '0;
    bus.br_taken = 1'b0; bus.dm_req = 1'b0; bus.dm_ready = 1'b0;
    @(posedge clk);
    #1;
    // reset held with a live load-use hazard on the inputs
    cyc(1, 5, 0, 0, 1, 1, 5, 0, 0, 0, NONE, 0, "rst_hold");
    idle(NONE, 0, "idle0");
    cyc(0, 5, 0, 0, 1, 1, 5, 0, 0, 0, SIF | BEX, 0, "lu_rs1");
    idle(NONE, 1, "idle1");
    cyc(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, NONE, 1, "lu_x0");
    cyc(0, 1, 7, 0, 1, 1, 7, 0, 0, 0, NONE, 1, "rs2_unused");
    cyc(0, 1, 7, 1, 1, 1, 7, 0, 0, 0, SIF | BEX, 1, "rs2_used");
    cyc(0, 5, 0, 0, 1, 1, 5, 1, 0, 0, FIF | BEX, 2, "br_over_lu");
    cyc(0, 5, 0, 0, 1, 0, 5, 0, 0, 0, NONE, 2, "no_wen");
    // 3-cycle memory wait
    mreq(1, 0, FULL, 2, "mw_enter");
    mreq(1, 0, FULL | MW, 3, "mw_2");
    mreq(1, 0, FULL | MW, 4, "mw_3");
    mreq(1, 1, MW, 5, "mw_ready");
    idle(NONE, 5, "mw_done");
    // dm_req dropping mid-wait, branch on the ready cycle
    mreq(1, 0, FULL, 5, "mw2_enter");
    mreq(0, 0, FULL | MW, 6, "mw2_req_low");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FIF | BEX | MW, 7, "mw2_ready_br");
    mreq(1, 1, NONE, 7, "req_ready_run");
    // timeout: 15 stall cycles, then abort
    mreq(1, 0, FULL, 7, "to_enter");
    for (int i = 0; i < 14; i++)
      mreq(1, 0, FULL | MW, 8 + i, "to_wait");
    mreq(1, 0, ABT | BWB | MW, 22, "to_abort");
    idle(TMO, 22, "to_sticky");
    // reset in the second cycle of a wait
    mreq(1, 0, FULL | TMO, 22, "rw_enter");
    mreq(1, 0, FULL | TMO | MW, 23, "rw_2");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, "rw_rst");
    idle(NONE, 0, "rw_after");
    idle(NONE, 0, "rw_after2");
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
